// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, exact CLK_DIV-cycle bit period, LSB-first framing.
// Define UART_TX_PARITY_EN to add a parity bit after the MSB (sense set by PARITY_ODD).
module uart_tx #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [DATA_BITS-1:0] iData,
    input  logic                 iValid,
    output logic                 oReady,
    output logic                 oTxPin,
    output logic                 oBusy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BAUD_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
`endif

    // tx_d is the line level for the next cycle, so oTxPin stays a pure register output.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (iValid) begin
                    state_d  = START;
                    shift_d  = iData;
                    bit_d    = '0;
                    tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^iData) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign oReady = (state_q == IDLE);
    assign oBusy  = ~oReady;
    assign oTxPin = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four lanes with different parameters; per-lane monitors
// decode the serial line cycle by cycle against hand-written expected level strings.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] data   [4];
    logic       valid  [4];
    logic       ready  [4];
    logic       tx_pin [4];
    logic       busy   [4];

    localparam int DIV [4] = '{4, 4, 2, 4};

    // Expected line levels per bit period, in time order (start bit first).
`ifdef UART_TX_PARITY_EN
    localparam string S_A5  = "01010010101";
    localparam string S_E07 = "01110000011";
    localparam string S_O07 = "01110000001";
    localparam string S_3C  = "00011110001";
    localparam string S_55  = "010101010011";
    localparam string S_0F  = "011110000011";
    localparam string S_1F  = "01111111";
`else
    localparam string S_A5  = "0101001011";
    localparam string S_E07 = "0111000001";
    localparam string S_O07 = "0111000001";
    localparam string S_3C  = "0001111001";
    localparam string S_55  = "01010101011";
    localparam string S_0F  = "01111000011";
    localparam string S_1F  = "0111111";
`endif
    localparam string S_F0_HEAD = "000";

    typedef struct {
        logic [15:0] seq;
        int          nper;
        int          div;
        bit          full;
        int          gap;
    } frame_t;

    frame_t exp_q [4][$];
    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_even (
        .CLK(clk), .RSTn(rst_n), .iData(data[0]), .iValid(valid[0]),
        .oReady(ready[0]), .oTxPin(tx_pin[0]), .oBusy(busy[0]));
    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_stop2 (
        .CLK(clk), .RSTn(rst_n), .iData(data[1]), .iValid(valid[1]),
        .oReady(ready[1]), .oTxPin(tx_pin[1]), .oBusy(busy[1]));
    uart_tx #(.CLK_DIV(2), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) u_narrow (
        .CLK(clk), .RSTn(rst_n), .iData(data[2][4:0]), .iValid(valid[2]),
        .oReady(ready[2]), .oTxPin(tx_pin[2]), .oBusy(busy[2]));
    uart_tx #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_odd (
        .CLK(clk), .RSTn(rst_n), .iData(data[3]), .iValid(valid[3]),
        .oReady(ready[3]), .oTxPin(tx_pin[3]), .oBusy(busy[3]));

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic frame_t mk(input string s, input int div, input bit full, input int gap);
        frame_t f;
        f.seq = '0;
        for (int i = 0; i < s.len(); i++) f.seq[i] = (s[i] == 8'h31);
        f.nper = s.len();
        f.div  = div;
        f.full = full;
        f.gap  = gap;
        return f;
    endfunction

    // Waits for a falling edge from idle, then checks every cycle of each bit period.
    task automatic monitor(input int ln);
        logic   prev = 1'b1;
        logic   rdy_last = 1'b0;
        int     idle = 0;
        int     m;
        frame_t f;
        forever begin
            @(negedge clk);
            if (prev && !tx_pin[ln]) begin
                if (exp_q[ln].size() == 0) begin
                    check($sformatf("lane%0d unexpected_frame", ln), 1, 0);
                    prev = 1'b0;
                end else begin
                    f = exp_q[ln].pop_front();
                    if (f.gap >= 0)
                        check($sformatf("lane%0d idle_gap", ln), idle, f.gap);
                    for (int p = 0; p < f.nper; p++) begin
                        m = 0;
                        for (int c = 0; c < f.div; c++) begin
                            if (!(p == 0 && c == 0)) @(negedge clk);
                            if (tx_pin[ln] === f.seq[p]) m++;
                        end
                        rdy_last = ready[ln];
                        check($sformatf("lane%0d period%0d cycles_at_level%0d", ln, p, f.seq[p]),
                              m, f.div);
                    end
                    if (f.full) begin
                        check($sformatf("lane%0d ready_low_last_cycle", ln), rdy_last, 0);
                        @(negedge clk);
                        check($sformatf("lane%0d ready_after_frame", ln), ready[ln], 1);
                        prev = tx_pin[ln];
                        idle = tx_pin[ln] ? 1 : 0;
                    end else begin
                        prev = 1'b0;
                        idle = 0;
                    end
                end
            end else begin
                idle = tx_pin[ln] ? idle + 1 : 0;
                prev = tx_pin[ln];
            end
        end
    endtask

    task automatic send(input int ln, input logic [7:0] d, input string s, input bit full);
        int n = 0;
        @(negedge clk);
        valid[ln] = 1'b1;
        data[ln]  = d;
        while (!ready[ln] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("lane%0d accept_ready", ln), ready[ln], 1);
        exp_q[ln].push_back(mk(s, DIV[ln], full, -1));
        @(posedge clk);
        #1;
        valid[ln] = 1'b0;
        data[ln]  = ~d;
    endtask

    task automatic wait_done(input int ln);
        int n = 0;
        while ((exp_q[ln].size() != 0 || !ready[ln]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("lane%0d frame_done_in_time", ln), (n < 400) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b0;
            data[i]  = '0;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none

        // Reset held for three cycles, then released.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) rst_n = 1'b1;
            #1;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("reset%0d lane%0d tx", c, i), tx_pin[i], 1);
                check($sformatf("reset%0d lane%0d ready", c, i), ready[i], 1);
                check($sformatf("reset%0d lane%0d busy", c, i), busy[i], 0);
            end
        end

        // Single frames, including parity sense on lanes 0 (even) and 3 (odd).
        send(0, 8'hA5, S_A5, 1'b1);
        wait_done(0);
        send(0, 8'h07, S_E07, 1'b1);
        wait_done(0);
        send(3, 8'h07, S_O07, 1'b1);
        wait_done(3);

        // Back-to-back with iValid held high; iData changes while the first frame is on the line.
        @(negedge clk);
        valid[1] = 1'b1;
        data[1]  = 8'h55;
        exp_q[1].push_back(mk(S_55, DIV[1], 1'b1, -1));
        @(posedge clk);
        #1;
        data[1] = 8'h0F;
        exp_q[1].push_back(mk(S_0F, DIV[1], 1'b1, 1));
        check("lane1 busy_after_accept", busy[1], 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[1] && n < 200);
        check("lane1 second_accept_ready", ready[1], 1);
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        wait_done(1);

        // Minimum divider and data width.
        send(2, 8'h1F, S_1F, 1'b1);
        wait_done(2);

        // Reset during the third data bit aborts the frame asynchronously.
        send(0, 8'hF0, S_F0_HEAD, 1'b0);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset tx_immediate", tx_pin[0], 1);
        check("midreset busy", busy[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset ready_after_release", ready[0], 1);
        send(0, 8'h3C, S_3C, 1'b1);
        wait_done(0);

        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("lane%0d scoreboard_drained", i), exp_q[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
